// File: rtl/dot_div_if.sv
// Operand/result FIFO bundle for the dot_div stage: two first-word-fallthrough
// operand FIFOs in, one result FIFO out.
interface dot_div_if;
  logic [31:0] num;
  logic        num_empty;
  logic        num_rd_en;
  logic [31:0] den;
  logic        den_empty;
  logic        den_rd_en;
  logic [31:0] out;
  logic        out_hit;
  logic        out_full;
  logic        out_wr_en;

  // Divider side: pops operands, pushes results.
  modport master (
    input  num, num_empty, den, den_empty, out_full,
    output num_rd_en, den_rd_en, out, out_hit, out_wr_en
  );

  // FIFO side: supplies operands, absorbs results.
  modport slave (
    output num, num_empty, den, den_empty, out_full,
    input  num_rd_en, den_rd_en, out, out_hit, out_wr_en
  );
endinterface

// File: rtl/dot_div.sv
// Iterative signed Q-format divider t = num / den, one quotient bit per cycle.
// Define DOT_DIV_SATURATE_EN to clamp out-of-range quotients instead of wrapping.
module dot_div #(
  parameter int Q_BITS = 10
) (
  input logic       clock,
  input logic       reset,
  dot_div_if.master bus
);
  localparam int DW = 32 + Q_BITS;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, DIV, WRITE} state_t;

  state_t         state;
  state_t         state_next;
  logic [DW-1:0]  dividend;
  logic [31:0]    divisor;
  logic [32:0]    rem;
  logic [CW-1:0]  count;
  logic           neg;
  logic [31:0]    out_q;
  logic           hit_q;

  logic           pop;
  logic           den_zero;
  logic [32:0]    num_ext;
  logic [32:0]    den_ext;
  logic [32:0]    num_abs;
  logic [32:0]    den_abs;
  logic [32:0]    rem_shift;
  logic [32:0]    rem_diff;
  logic           q_bit;
  logic [DW-1:0]  quot_final;
  logic [DW-1:0]  quot_signed;
  logic [31:0]    result;

  // 33-bit magnitudes so that -2^31 has a representable absolute value.
  assign num_ext  = {bus.num[31], bus.num};
  assign den_ext  = {bus.den[31], bus.den};
  assign num_abs  = bus.num[31] ? (33'd0 - num_ext) : num_ext;
  assign den_abs  = bus.den[31] ? (33'd0 - den_ext) : den_ext;
  assign den_zero = (bus.den == 32'd0);

  // Pops and pushes are held off while reset is asserted.
  assign pop           = (state == IDLE) && !bus.num_empty && !bus.den_empty && reset;
  assign bus.num_rd_en = pop;
  assign bus.den_rd_en = pop;
  assign bus.out_wr_en = (state == WRITE) && !bus.out_full && reset;
  assign bus.out       = out_q;
  assign bus.out_hit   = hit_q;

  // The dividend register doubles as the quotient shift register.
  assign rem_shift  = {rem[31:0], dividend[DW-1]};
  assign rem_diff   = rem_shift - {1'b0, divisor};
  assign q_bit      = (rem_shift >= {1'b0, divisor});
  assign quot_final = {dividend[DW-2:0], q_bit};

  always_comb begin
    quot_signed = neg ? (~quot_final + 1'b1) : quot_final;
    result      = quot_signed[31:0];
`ifdef DOT_DIV_SATURATE_EN
    if (!neg && (quot_final > DW'(32'h7FFF_FFFF)))
      result = 32'h7FFF_FFFF;
    else if (neg && (quot_final > DW'(32'h8000_0000)))
      result = 32'h8000_0000;
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = den_zero ? WRITE : DIV;
      DIV:     if (count == CW'(1)) state_next = WRITE;
      WRITE:   if (!bus.out_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      count    <= '0;
      neg      <= 1'b0;
      out_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pop) begin
            dividend <= {num_abs[31:0], {Q_BITS{1'b0}}};
            divisor  <= den_abs[31:0];
            rem      <= '0;
            neg      <= bus.num[31] ^ bus.den[31];
            count    <= CW'(DW);
            if (den_zero) begin
              out_q <= 32'h7FFF_FFFF;
              hit_q <= 1'b0;
            end
          end
        end
        DIV: begin
          dividend <= quot_final;
          rem      <= q_bit ? rem_diff : rem_shift;
          count    <= count - 1'b1;
          if (count == CW'(1)) begin
            out_q <= result;
            hit_q <= ($signed(result) > 0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_div.sv
// Directed bench for dot_div: hand-computed Q10 quotients, latency, FIFO
// back-pressure and mid-division reset.
module tb_dot_div;
  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   num_pops;
  int   den_pops;
  int   writes;

  dot_div_if bus();

  dot_div #(.Q_BITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Handshake counters used to prove single pops and single writes.
  always @(posedge clock) begin
    if (bus.num_rd_en) num_pops <= num_pops + 1;
    if (bus.den_rd_en) den_pops <= den_pops + 1;
    if (bus.out_wr_en) writes   <= writes + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [31:0] n, input logic [31:0] d,
                                input logic [31:0] exp_out, input logic exp_hit, input int exp_lat);
    int cyc;
    int np0;
    int dp0;
    int w0;
    @(negedge clock);
    np0 = num_pops;
    dp0 = den_pops;
    w0  = writes;
    bus.num       = n;
    bus.den       = d;
    bus.num_empty = 1'b0;
    bus.den_empty = 1'b0;
    #1;
    check_output({tag, "_pop"}, 32'(bus.num_rd_en & bus.den_rd_en), 32'd1);
    @(negedge clock);
    bus.num_empty = 1'b1;
    bus.den_empty = 1'b1;
    cyc = 1;
    while (!bus.out_wr_en && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check_output({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check_output({tag, "_out"}, bus.out, exp_out);
    check_output({tag, "_hit"}, 32'(bus.out_hit), 32'(exp_hit));
    @(negedge clock);
    check_output({tag, "_num_pops"}, 32'(num_pops - np0), 32'd1);
    check_output({tag, "_den_pops"}, 32'(den_pops - dp0), 32'd1);
    check_output({tag, "_writes"}, 32'(writes - w0), 32'd1);
  endtask

  initial begin
    int np0;
    int dp0;
    int w0;
    int stray;
    checks        = 0;
    failures      = 0;
    num_pops      = 0;
    den_pops      = 0;
    writes        = 0;
    reset         = 1'b0;
    bus.num       = '0;
    bus.den       = '0;
    bus.num_empty = 1'b1;
    bus.den_empty = 1'b1;
    bus.out_full  = 1'b0;

    // Reset state.
    repeat (2) @(negedge clock);
    check_output("rst_out", bus.out, 32'd0);
    check_output("rst_hit", 32'(bus.out_hit), 32'd0);
    check_output("rst_wr_en", 32'(bus.out_wr_en), 32'd0);
    check_output("rst_rd_en", 32'(bus.num_rd_en | bus.den_rd_en), 32'd0);
    reset = 1'b1;

    // Basic quotients in Q10.
    apply_stimulus("two", 32'd2048, 32'd1024, 32'd2048, 1'b1, 43);
    apply_stimulus("neg_num", -32'sd3072, 32'd2048, -32'sd1536, 1'b0, 43);
    apply_stimulus("trunc", 32'd3, -32'sd7, -32'sd438, 1'b0, 43);
    apply_stimulus("den_zero", 32'd5000, 32'd0, 32'h7FFF_FFFF, 1'b0, 1);
    apply_stimulus("min_min", 32'h8000_0000, 32'h8000_0000, 32'd1024, 1'b1, 43);
`ifdef DOT_DIV_SATURATE_EN
    apply_stimulus("overflow", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b1, 43);
`else
    apply_stimulus("overflow", 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FC00, 1'b0, 43);
`endif

    // Numerator ready while denominator FIFO stays empty.
    @(negedge clock);
    bus.num       = 32'd4096;
    bus.den       = 32'd1024;
    bus.num_empty = 1'b0;
    bus.den_empty = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.num_rd_en || bus.den_rd_en) stray++;
      @(negedge clock);
    end
    check_output("den_empty_no_pop", 32'(stray), 32'd0);
    np0 = num_pops;
    dp0 = den_pops;
    bus.den_empty = 1'b0;
    bus.out_full  = 1'b1;
    #1;
    check_output("den_release_pop", 32'(bus.num_rd_en & bus.den_rd_en), 32'd1);
    @(negedge clock);
    bus.num_empty = 1'b1;
    bus.den_empty = 1'b1;
    repeat (42) @(negedge clock);

    // Result FIFO full for 10 cycles in WRITE.
    w0    = writes;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out !== 32'd4096 || bus.out_hit !== 1'b1 || bus.out_wr_en !== 1'b0) stray++;
      @(negedge clock);
    end
    check_output("full_hold_stable", 32'(stray), 32'd0);
    check_output("full_hold_no_write", 32'(writes - w0), 32'd0);
    bus.out_full = 1'b0;
    #1;
    check_output("full_release_wr_en", 32'(bus.out_wr_en), 32'd1);
    check_output("full_release_out", bus.out, 32'd4096);
    @(negedge clock);
    check_output("full_release_writes", 32'(writes - w0), 32'd1);
    check_output("full_release_idle", 32'(bus.out_wr_en), 32'd0);
    check_output("full_num_pops", 32'(num_pops - np0), 32'd1);
    check_output("full_den_pops", 32'(den_pops - dp0), 32'd1);

    // Reset pulled during DIV cycle 15.
    bus.num       = 32'd2048;
    bus.den       = 32'd1024;
    bus.num_empty = 1'b0;
    bus.den_empty = 1'b0;
    @(negedge clock);
    bus.num_empty = 1'b1;
    bus.den_empty = 1'b1;
    repeat (14) @(negedge clock);
    w0 = writes;
    bus.num_empty = 1'b0;
    bus.den_empty = 1'b0;
    reset = 1'b0;
    #1;
    check_output("mid_rst_out", bus.out, 32'd0);
    check_output("mid_rst_hit", 32'(bus.out_hit), 32'd0);
    check_output("mid_rst_wr_en", 32'(bus.out_wr_en), 32'd0);
    check_output("mid_rst_rd_en", 32'(bus.num_rd_en | bus.den_rd_en), 32'd0);
    @(negedge clock);
    bus.num_empty = 1'b1;
    bus.den_empty = 1'b1;
    reset = 1'b1;
    repeat (50) @(negedge clock);
    check_output("mid_rst_no_write", 32'(writes - w0), 32'd0);
    apply_stimulus("post_rst", 32'd3072, 32'd1024, 32'd3072, 1'b1, 43);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dot_div.md
# dot_div

Signed fixed-point divider stage that consumes two dot-product result FIFOs (numerator and denominator) and produces the ray parameter t = num / den in the same Q format, plus a hit flag. It sits directly downstream of two `dot` blocks in the ray–plane / ray–triangle intersection path and writes into a result FIFO read by the hit-selection logic. Division is iterative (one quotient bit per cycle), trading throughput for area.

## Interface
- Q_BITS, 10, fractional bits of all operands and of the result
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- num  input  32  signed Q numerator, first-word-fallthrough (valid while !num_empty)
- num_empty  input  1  numerator FIFO empty
- num_rd_en  output  1  pop numerator FIFO
- den  input  32  signed Q denominator, first-word-fallthrough
- den_empty  input  1  denominator FIFO empty
- den_rd_en  output  1  pop denominator FIFO
- out  output  32  signed Q quotient t
- out_hit  output  1  1 when den != 0 and t > 0
- out_full  input  1  result FIFO full
- out_wr_en  output  1  push {out_hit, out} into result FIFO

## Operation
- States: IDLE, DIV, WRITE.
- IDLE: when !num_empty && !den_empty, assert num_rd_en and den_rd_en together (same cycle, combinational); latch |num| << Q_BITS as (32+Q_BITS)-bit dividend, |den| as 32-bit divisor, neg = sign(num) XOR sign(den). Never pop one FIFO without the other.
- IDLE with den == 0: skip DIV; next state WRITE with out = 32'h7FFF_FFFF, out_hit = 0.
- DIV: restoring division, MSB first, 33-bit partial remainder, 32+Q_BITS iterations via down-counter; then WRITE.
- Result: magnitude quotient truncated toward zero; negate if neg. Quotient exceeding signed 32-bit range handled per Configuration.
- out_hit = (den != 0) && (out > 0), computed on the final (post-saturation/wrap) value.
- WRITE: out and out_hit stable; assert out_wr_en when !out_full; on that cycle go to IDLE. Hold in WRITE while out_full.
- Magnitude of -2^31 operands: take absolute value in 33 bits, no overflow.

## Timing
- Reset (reset low, async): state IDLE, out = 0, out_hit = 0, counter = 0; num_rd_en, den_rd_en, out_wr_en = 0 while reset low.
- Latency, nonzero den: pop at cycle 0, DIV cycles 1..32+Q_BITS, out_wr_en earliest at cycle 33+Q_BITS (43 for Q_BITS=10).
- Latency, zero den: out_wr_en earliest at cycle 1.
- Throughput: one result per 34+Q_BITS cycles max; no pop in DIV or WRITE.
- out/out_hit registered; change only on transition into WRITE.
- out_full sampled combinationally in WRITE; out_full rising in the same cycle as WRITE entry blocks the write.
- Reset mid-DIV or mid-WRITE: operation discarded, no write, popped operands lost.

## Configuration
- DOT_DIV_SATURATE_EN defined: quotient magnitude > 2^31-1 clamps to 32'h7FFF_FFFF (positive) or 32'h8000_0000 (negative).
- Undefined: low 32 bits of the signed quotient are output (two's-complement wrap); no overflow detection logic synthesized.

## Test plan
- num=2048, den=1024 (Q10) -> out=2048, out_hit=1, out_wr_en at cycle 43 after pop, single pop of each FIFO.
- num=-3072, den=2048 -> out=-1536, out_hit=0; num=3, den=-7 -> out=-438 (truncate toward zero), out_hit=0.
- num=5000, den=0 -> out=32'h7FFF_FFFF, out_hit=0, out_wr_en at cycle 1.
- num=32'h7FFF_FFFF, den=1 -> with DOT_DIV_SATURATE_EN out=32'h7FFF_FFFF, out_hit=1; without, out=32'hFFFF_FC00, out_hit=0.
- num ready, den_empty=1 for 20 cycles -> no rd_en on either FIFO; pops on first cycle den_empty=0; out_full held 1 for 10 cycles in WRITE -> out stable, single write when released.
- reset pulled low at DIV cycle 15 -> outputs 0 immediately, state IDLE, no out_wr_en; next operand pair processed normally.
